// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and data requesters of the core.
// Fixed-length accesses, round-robin on ties, registered acks and read data.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic              busy_o
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [3:0]        r_cnt;
  logic              r_last_d;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic              r_if_ack;
  logic              r_dm_ack;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              w_if_elig;
  logic              w_dm_elig;
  logic              w_grant_i;
  logic              w_grant_d;
  logic              w_done;
  logic              w_busy;

  // A requester sitting in its ack cycle still holds req; it must not be re-granted.
  assign w_if_elig = if_req_i & ~r_if_ack;
  assign w_dm_elig = dm_req_i & ~r_dm_ack;

  always_comb begin
    w_state_next = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_dm_elig && (!w_if_elig || !r_last_d)) begin
          w_grant_d    = 1'b1;
          w_state_next = BUSY_D;
        end else if (w_if_elig) begin
          w_grant_i    = 1'b1;
          w_state_next = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (r_cnt == 4'd0) begin
          w_done       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt      <= 4'd0;
      r_last_d   <= 1'b0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_if_ack   <= 1'b0;
      r_dm_ack   <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      r_if_ack <= w_done && (r_state == BUSY_I);
      r_dm_ack <= w_done && (r_state == BUSY_D);
      if (w_grant_i || w_grant_d) begin
        r_cnt    <= CNT_INIT;
        r_last_d <= w_grant_d;
      end else if (w_busy && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_grant_i) begin
        r_addr  <= if_addr_i;
        r_we    <= 1'b0;
        r_wdata <= '0;
      end
      if (w_grant_d) begin
        r_addr  <= dm_addr_i;
        r_we    <= dm_we_i;
        r_wdata <= dm_wdata_i;
      end
      if (w_done && (r_state == BUSY_I)) begin
        r_if_rdata <= mem_rdata_i;
      end
      if (w_done && (r_state == BUSY_D) && !r_we) begin
        r_dm_rdata <= mem_rdata_i;
      end
    end
  end

  // Write strobe only in the final busy cycle so an aborted store never commits.
  assign w_busy      = (r_state != IDLE);
  assign busy_o      = w_busy;
  assign mem_en_o    = w_busy;
  assign mem_we_o    = (r_state == BUSY_D) && r_we && (r_cnt == 4'd0);
  assign mem_addr_o  = w_busy ? r_addr : '0;
  assign mem_wdata_o = w_busy ? r_wdata : '0;
  assign if_ack_o    = r_if_ack;
  assign dm_ack_o    = r_dm_ack;
  assign if_rdata_o  = r_if_rdata;
  assign dm_rdata_o  = r_dm_rdata;
  assign stall_o     = (if_req_i & ~r_if_ack) | (dm_req_i & ~r_dm_ack);

endmodule
